// File: rtl/alu_tr_pkg.sv
// alu_tr_pkg: shared definitions for the time-redundant ALU.
//   - opcode encodings for the ALU core
//   - controller state encoding
//   - word_width(): width of a compared word {Result, Zero, Carry, OverFlow, Negative}
package alu_tr_pkg;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic int word_width(input int w);
        return w + 4;
    endfunction

endpackage

// File: rtl/alu_core.sv
// alu_core: purely combinational ALU shared by every execution of an operation.
// Ports:
//   A, B        in  [WIDTH]  operands
//   ALUControl  in  [3]      opcode (alu_tr_pkg OP_*); 100/101 yield zero
//   Result      out [WIDTH]  operation result
//   Zero        out          Result == 0
//   Carry       out          ADD carry-out, SUB not-borrow, else 0
//   OverFlow    out          signed overflow for ADD/SUB, else 0
//   Negative    out          Result MSB
module alu_core
    import alu_tr_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       ALUControl,
    output logic [WIDTH-1:0] Result,
    output logic             Zero,
    output logic             Carry,
    output logic             OverFlow,
    output logic             Negative
);

    logic [WIDTH-1:0] res_c;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic             sum_co;
    logic             diff_co;
    logic             carry_c;
    logic             ovf_c;
    logic             slt_c;

    // Subtraction as A + ~B + 1 so the carry-out is the not-borrow bit.
    assign {sum_co, sum}   = {1'b0, A} + {1'b0, B};
    assign {diff_co, diff} = {1'b0, A} + {1'b0, ~B} + (WIDTH+1)'(1);
    assign slt_c           = $signed(A) < $signed(B);

    always_comb begin
        res_c   = '0;
        carry_c = 1'b0;
        ovf_c   = 1'b0;
        case (ALUControl)
            OP_AND: res_c = A & B;
            OP_OR:  res_c = A | B;
            OP_XOR: res_c = A ^ B;
            OP_ADD: begin
                res_c   = sum;
                carry_c = sum_co;
                ovf_c   = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SUB: begin
                res_c   = diff;
                carry_c = diff_co;
                ovf_c   = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SLT: res_c = {{(WIDTH-1){1'b0}}, slt_c};
            default: res_c = '0;
        endcase
    end

    // Continuous drive keeps Result a simple net-like output of the core.
    assign Result   = res_c;
    assign Zero     = (res_c == '0);
    assign Carry    = carry_c;
    assign OverFlow = ovf_c;
    assign Negative = res_c[WIDTH-1];

endmodule

// File: rtl/alu_tr_vote.sv
// alu_tr_vote: time-redundant ALU. Each accepted operation is re-executed on one
// shared alu_core until two executions agree (up to MAX_TRIES), then the agreed
// result and flags are presented with a valid/ready handshake.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   in_valid / in_ready              operation handshake (A, B, ALUControl)
//   out_valid / out_ready            result handshake
//   Result, Zero, Carry, OverFlow, Negative   agreed result and flags
//   fault_detected_out               this operation saw at least one mismatch
//   uncorrectable                    no two executions agreed
//   fault_count [16]                 saturating count of faulted operations
// Optional macro ALU_TR_FAULT_INJ_EN adds inj_mask [WIDTH] and inj_tries
// [MAX_TRIES]: execution k with inj_tries[k] set has its Result XORed with
// inj_mask rotated left by k before Zero/Negative are derived.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | in_ready=1, waiting for an operation
// EXEC    | one execution per cycle, compared against earlier executions
// DONE    | out_valid=1, outputs held until out_ready
module alu_tr_vote
    import alu_tr_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int MAX_TRIES = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       ALUControl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Result,
    output logic             Zero,
    output logic             Carry,
    output logic             OverFlow,
    output logic             Negative,
    output logic             fault_detected_out,
    output logic             uncorrectable,
    output logic [15:0]      fault_count
`ifdef ALU_TR_FAULT_INJ_EN
    ,
    input  logic [WIDTH-1:0]     inj_mask,
    input  logic [MAX_TRIES-1:0] inj_tries
`endif
);

    localparam int WW = word_width(WIDTH);
    localparam int TW = $clog2(MAX_TRIES);
    // The final execution is never compared against later ones, so it needs no slot.
    localparam int NS = MAX_TRIES - 1;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [2:0]       op_q;
    logic [TW-1:0]    try_q;
    logic [WW-1:0]    slot_q [NS];
    logic [WW-1:0]    out_word_q;
    logic             fault_q;
    logic             unc_q;

    logic [WIDTH-1:0] core_res;
    logic             core_z;
    logic             core_c;
    logic             core_v;
    logic             core_n;
    logic [WIDTH-1:0] exec_res;
    logic             exec_z;
    logic             exec_n;
    logic [WW-1:0]    word_c;
    logic             match_c;
    logic             last_c;
    logic             done_c;

    alu_core #(.WIDTH(WIDTH)) u_alu (
        .A          (a_q),
        .B          (b_q),
        .ALUControl (op_q),
        .Result     (core_res),
        .Zero       (core_z),
        .Carry      (core_c),
        .OverFlow   (core_v),
        .Negative   (core_n)
    );

`ifdef ALU_TR_FAULT_INJ_EN
    logic [2*WIDTH-1:0] rot_wide;
    always_comb begin
        rot_wide = {inj_mask, inj_mask} << try_q;
        exec_res = core_res;
        if (inj_tries[try_q])
            exec_res = core_res ^ rot_wide[2*WIDTH-1:WIDTH];
        exec_z = (exec_res == '0);
        exec_n = exec_res[WIDTH-1];
    end
`else
    assign exec_res = core_res;
    assign exec_z   = core_z;
    assign exec_n   = core_n;
`endif

    assign word_c = {exec_res, exec_z, core_c, core_v, exec_n};

    // Any equal earlier slot means word_c itself is the agreed word.
    always_comb begin
        match_c = 1'b0;
        for (int j = 0; j < NS; j++) begin
            if ((TW'(j) < try_q) && (slot_q[j] == word_c))
                match_c = 1'b1;
        end
    end

    assign last_c = (try_q == TW'(NS));
    assign done_c = (state_q == ST_EXEC) && (match_c || last_c);

    always_ff @(posedge clk) begin
        if (rst)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (in_valid)  state_d = ST_EXEC;
            ST_EXEC: if (done_c)    state_d = ST_DONE;
            ST_DONE: if (out_ready) state_d = ST_IDLE;
            default:                state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == ST_IDLE);
        out_valid = (state_q == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            try_q       <= '0;
            out_word_q  <= '0;
            fault_q     <= 1'b0;
            unc_q       <= 1'b0;
            fault_count <= '0;
            for (int j = 0; j < NS; j++)
                slot_q[j] <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_q   <= A;
                        b_q   <= B;
                        op_q  <= ALUControl;
                        try_q <= '0;
                    end
                end
                ST_EXEC: begin
                    try_q <= try_q + TW'(1);
                    for (int j = 0; j < NS; j++) begin
                        if (try_q == TW'(j))
                            slot_q[j] <= word_c;
                    end
                    if (done_c) begin
                        out_word_q <= match_c ? word_c : slot_q[0];
                        unc_q      <= !match_c;
                        // Agreement on execution 1 means executions 0 and 1 matched: clean.
                        fault_q    <= !match_c || (try_q >= TW'(2));
                    end
                end
                ST_DONE: begin
                    if (out_ready && fault_q && (fault_count != 16'hFFFF))
                        fault_count <= fault_count + 16'd1;
                end
                default: ;
            endcase
        end
    end

    assign {Result, Zero, Carry, OverFlow, Negative} = out_word_q;
    assign fault_detected_out = fault_q;
    assign uncorrectable      = unc_q;

endmodule

// File: tb/tb_alu_tr_vote.sv
module tb_alu_tr_vote;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_valid5;
    logic        out_ready, out_ready5;
    logic [31:0] A, B;
    logic [2:0]  ALUControl;

    logic        in_ready, out_valid, Zero, Carry, OverFlow, Negative, fault_detected_out, uncorrectable;
    logic [31:0] Result;
    logic [15:0] fault_count;

    logic        in_ready5, out_valid5, Zero5, Carry5, OverFlow5, Negative5, fault5, unc5;
    logic [31:0] Result5;
    logic [15:0] fault_count5;

    int n_cmp = 0;
    int n_err = 0;
    int lat;
    logic [31:0] held;

    always #5 clk = ~clk;

    alu_tr_vote #(.WIDTH(32), .MAX_TRIES(3)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .ALUControl(ALUControl),
        .out_valid(out_valid), .out_ready(out_ready),
        .Result(Result), .Zero(Zero), .Carry(Carry), .OverFlow(OverFlow), .Negative(Negative),
        .fault_detected_out(fault_detected_out), .uncorrectable(uncorrectable),
        .fault_count(fault_count)
    );

    alu_tr_vote #(.WIDTH(32), .MAX_TRIES(5)) dut5 (
        .clk(clk), .rst(rst), .in_valid(in_valid5), .in_ready(in_ready5),
        .A(A), .B(B), .ALUControl(ALUControl),
        .out_valid(out_valid5), .out_ready(out_ready5),
        .Result(Result5), .Zero(Zero5), .Carry(Carry5), .OverFlow(OverFlow5), .Negative(Negative5),
        .fault_detected_out(fault5), .uncorrectable(unc5),
        .fault_count(fault_count5)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                          output int l);
        A = a; B = b; ALUControl = op; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        l = 0;
        while (!out_valid && l < 20) begin
            @(posedge clk); #1;
            l++;
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_valid5 = 1'b0; out_ready = 1'b0; out_ready5 = 1'b0;
        A = '0; B = '0; ALUControl = 3'b000;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_result", 64'(Result), 64'd0);
        chk("rst_flags", 64'({Zero, Carry, OverFlow, Negative}), 64'd0);
        chk("rst_fault_unc", 64'({fault_detected_out, uncorrectable}), 64'd0);
        chk("rst_fault_count", 64'(fault_count), 64'd0);

        // Clean ADD
        run_op(32'hF5, 32'hAA, 3'b010, lat);
        chk("add_latency", 64'(lat), 64'd2);
        chk("add_result", 64'(Result), 64'h19F);
        chk("add_flags", 64'({Zero, Carry, OverFlow, Negative}), 64'b0000);
        chk("add_fault", 64'({fault_detected_out, uncorrectable}), 64'd0);
        chk("add_in_ready", 64'(in_ready), 64'd0);
        consume();
        chk("add_back_idle", 64'(in_ready), 64'd1);
        chk("add_fault_count", 64'(fault_count), 64'd0);

        // SUB 0-1
        run_op(32'h0, 32'h1, 3'b110, lat);
        chk("sub_neg_result", 64'(Result), 64'hFFFF_FFFF);
        chk("sub_neg_flags", 64'({Zero, Carry, OverFlow, Negative}), 64'b0001);
        consume();

        // ADD signed overflow
        run_op(32'h7FFF_FFFF, 32'h1, 3'b010, lat);
        chk("add_ovf_result", 64'(Result), 64'h8000_0000);
        chk("add_ovf_flags", 64'({Zero, Carry, OverFlow, Negative}), 64'b0011);
        consume();

        // ADD with carry-out and zero result
        run_op(32'hFFFF_FFFF, 32'h1, 3'b010, lat);
        chk("add_carry_result", 64'(Result), 64'h0);
        chk("add_carry_flags", 64'({Zero, Carry, OverFlow, Negative}), 64'b1100);
        consume();

        // SUB without borrow
        run_op(32'h5, 32'h3, 3'b110, lat);
        chk("sub_pos_result", 64'(Result), 64'h2);
        chk("sub_pos_flags", 64'({Zero, Carry, OverFlow, Negative}), 64'b0100);
        consume();

        // SUB signed overflow: 0x80000000 - 1
        run_op(32'h8000_0000, 32'h1, 3'b110, lat);
        chk("sub_ovf_result", 64'(Result), 64'h7FFF_FFFF);
        chk("sub_ovf_flags", 64'({Zero, Carry, OverFlow, Negative}), 64'b0110);
        consume();

        // SLT signed -1 < 1
        run_op(32'hFFFF_FFFF, 32'h1, 3'b111, lat);
        chk("slt_result", 64'(Result), 64'h1);
        chk("slt_flags", 64'({Zero, Carry, OverFlow, Negative}), 64'b0000);
        consume();

        // Logic ops and an unused opcode
        run_op(32'hF0F0_1234, 32'h0FF0_FF00, 3'b000, lat);
        chk("and_result", 64'(Result), 64'h00F0_1200);
        consume();
        run_op(32'hF0F0_1234, 32'h0FF0_FF00, 3'b001, lat);
        chk("or_result", 64'(Result), 64'hFFF0_FF34);
        chk("or_flags", 64'({Zero, Carry, OverFlow, Negative}), 64'b0001);
        consume();
        run_op(32'hF0F0_1234, 32'h0FF0_FF00, 3'b011, lat);
        chk("xor_result", 64'(Result), 64'hFF00_ED34);
        consume();
        run_op(32'h1234_5678, 32'h1, 3'b100, lat);
        chk("op100_result", 64'(Result), 64'h0);
        chk("op100_flags", 64'({Zero, Carry, OverFlow, Negative}), 64'b1000);
        consume();

        // Execution 1 corrupted with mask 0xFFFFFFFF: execution 2 agrees with 0
        A = 32'hF5; B = 32'hAA; ALUControl = 3'b010; in_valid = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        @(posedge clk); #1 force dut.u_alu.Result = 32'hFFFF_FE60;
        @(posedge clk); #1 release dut.u_alu.Result;
        chk("inj1_not_yet", 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        chk("inj1_valid_3cyc", 64'(out_valid), 64'd1);
        chk("inj1_result", 64'(Result), 64'h19F);
        chk("inj1_fault_unc", 64'({fault_detected_out, uncorrectable}), 64'b10);
        consume();
        chk("inj1_fault_count", 64'(fault_count), 64'd1);

        // Every execution corrupted: uncorrectable, slot 0 returned
        in_valid = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        force dut.u_alu.Result = 32'h19E;
        @(posedge clk); #1 force dut.u_alu.Result = 32'h19D;
        @(posedge clk); #1 force dut.u_alu.Result = 32'h19B;
        @(posedge clk); #1 release dut.u_alu.Result;
        chk("unc_valid_3cyc", 64'(out_valid), 64'd1);
        chk("unc_result", 64'(Result), 64'h19E);
        chk("unc_fault_unc", 64'({fault_detected_out, uncorrectable}), 64'b11);

        // Stall with a new offer pending: outputs frozen, offer ignored
        held = Result;
        A = 32'h1111_1111; B = 32'h2222_2222; ALUControl = 3'b001; in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("stall_result", 64'(Result), 64'(held));
            chk("stall_hs", 64'({in_ready, out_valid, uncorrectable}), 64'b011);
        end
        in_valid = 1'b0;
        consume();
        chk("unc_fault_count", 64'(fault_count), 64'd2);
        @(posedge clk); #1;
        chk("stall_offer_dropped", 64'(out_valid), 64'd0);

        // Reset during EXEC aborts the operation
        A = 32'h3; B = 32'h4; ALUControl = 3'b010; in_valid = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0; rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        chk("abort_in_ready", 64'(in_ready), 64'd1);
        chk("abort_out_valid", 64'(out_valid), 64'd0);
        chk("abort_result", 64'(Result), 64'd0);
        chk("abort_flags", 64'({Zero, Carry, OverFlow, Negative, fault_detected_out, uncorrectable}), 64'd0);
        chk("abort_fault_count", 64'(fault_count), 64'd0);
        repeat (3) @(posedge clk);
        #1 chk("abort_no_output", 64'(out_valid), 64'd0);

        // Normal operation after abort
        run_op(32'h3, 32'h4, 3'b010, lat);
        chk("post_abort_latency", 64'(lat), 64'd2);
        chk("post_abort_result", 64'(Result), 64'h7);
        consume();

        // MAX_TRIES=5: executions 0..2 corrupted, 3 and 4 agree
        A = 32'hF5; B = 32'hAA; ALUControl = 3'b010; in_valid5 = 1'b1;
        @(posedge clk); #1 in_valid5 = 1'b0;
        force dut5.u_alu.Result = 32'h19E;
        @(posedge clk); #1 force dut5.u_alu.Result = 32'h19D;
        @(posedge clk); #1 force dut5.u_alu.Result = 32'h19B;
        @(posedge clk); #1 release dut5.u_alu.Result;
        chk("t5_wait_e3", 64'(out_valid5), 64'd0);
        @(posedge clk); #1;
        chk("t5_wait_e4", 64'(out_valid5), 64'd0);
        @(posedge clk); #1;
        chk("t5_valid_5cyc", 64'(out_valid5), 64'd1);
        chk("t5_result", 64'(Result5), 64'h19F);
        chk("t5_fault_unc", 64'({fault5, unc5}), 64'b10);
        out_ready5 = 1'b1;
        @(posedge clk); #1 out_ready5 = 1'b0;
        chk("t5_fault_count", 64'(fault_count5), 64'd1);
        chk("t5_in_ready", 64'(in_ready5), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
